// File: rtl/multicycle_alu_if.sv
// Operand/result bundle and start/busy/done handshake
// between the multi-cycle control and the ALU.
interface multicycle_alu_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
);
  logic             start;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_hi;
  logic             flag;
  logic             div_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, alu_op, alu_a, alu_b,
    input  alu_out, alu_hi, flag,
    input  div_zero, busy, done
  );

  modport slave (
    input  start, alu_op, alu_a, alu_b,
    output alu_out, alu_hi, flag,
    output div_zero, busy, done
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multi-cycle MIPS ALU: one-cycle arithmetic/logic/shift ops,
// iterative shift-add multiply and restoring divide into HI/LO.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5,
  parameter int SH_W  = 5
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_alu_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, MUL, DIV, FIN
  } state_t;

  localparam logic [OP_W-1:0] OP_ZERO  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BGTZ  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(14);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(16);

  state_t             state;
  logic [SH_W-1:0]    cnt;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH-1:0]   mcand;
  logic               is_mul;
  logic               neg_lo;
  logic               neg_hi;
  logic               dz_r;
  logic [WIDTH-1:0]   out_r;
  logic [WIDTH-1:0]   hi_r;
  logic               flag_r;
  logic               dz_out;
  logic               busy_r;
  logic               done_r;

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SH_W-1:0]    sh;
  logic               sgn_a;
  logic               sgn_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               op_mul;
  logic               op_div;
  logic               op_sgn;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;

  assign a      = bus.alu_a;
  assign b      = bus.alu_b;
  assign sh     = b[SH_W-1:0];
  assign sgn_a  = a[WIDTH-1];
  assign sgn_b  = b[WIDTH-1];
  assign abs_a  = sgn_a ? -a : a;
  assign abs_b  = sgn_b ? -b : b;
  assign op_mul = (bus.alu_op == OP_MULT)
               || (bus.alu_op == OP_MULTU);
  assign op_div = (bus.alu_op == OP_DIV)
               || (bus.alu_op == OP_DIVU);
  assign op_sgn = (bus.alu_op == OP_MULT)
               || (bus.alu_op == OP_DIV);
  assign opa    = op_sgn ? abs_a : a;
  assign opb    = op_sgn ? abs_b : b;

  logic [WIDTH-1:0] sc_res;
  logic             sc_flag;

  always_comb begin
    sc_res  = '0;
    sc_flag = 1'b0;
    case (bus.alu_op)
      OP_ZERO: sc_res = '0;
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_BGTZ: sc_flag = !sgn_a && (a != '0);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         $signed(a) < $signed(b)};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = $signed(a) >>> sh;
      OP_MULT, OP_MULTU,
      OP_DIV, OP_DIVU: sc_res = '0;
      default: sc_res = WIDTH'({(WIDTH/4+1){4'hC}});
    endcase
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rs;
  logic               ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;

  assign mul_sum  = {1'b0, p_hi}
                  + (p_lo[0] ? {1'b0, mcand} : '0);
  assign rs       = {p_hi, p_lo[WIDTH-1]};
  assign ge       = rs >= {1'b0, mcand};
  // rs < 2*divisor, so the difference fits in WIDTH bits
  assign rem_sub  = rs[WIDTH-1:0] - mcand;
  assign prod     = {p_hi, p_lo};
  assign prod_fix = neg_lo ? -prod : prod;

  always_comb begin
    fin_lo = neg_lo ? -p_lo : p_lo;
    fin_hi = neg_hi ? -p_hi : p_hi;
    if (is_mul) begin
      fin_lo = prod_fix[WIDTH-1:0];
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      mcand  <= '0;
      is_mul <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz_r   <= 1'b0;
      out_r  <= '0;
      hi_r   <= '0;
      flag_r <= 1'b0;
      dz_out <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt  <= SH_W'(WIDTH-1);
            dz_r <= 1'b0;
            if (op_mul) begin
              is_mul <= 1'b1;
              mcand  <= opa;
              p_lo   <= opb;
              p_hi   <= '0;
              neg_lo <= op_sgn && (sgn_a ^ sgn_b);
              neg_hi <= 1'b0;
              busy_r <= 1'b1;
              state  <= MUL;
            end else if (op_div) begin
              is_mul <= 1'b0;
              busy_r <= 1'b1;
              if (b == '0) begin
                p_lo   <= '1;
                p_hi   <= a;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                dz_r   <= 1'b1;
                state  <= FIN;
              end else begin
                p_lo   <= opa;
                p_hi   <= '0;
                mcand  <= opb;
                neg_lo <= op_sgn && (sgn_a ^ sgn_b);
                neg_hi <= op_sgn && sgn_a;
                state  <= DIV;
              end
            end else begin
              out_r  <= sc_res;
              hi_r   <= '0;
              flag_r <= sc_flag;
              dz_out <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        MUL: begin
          p_hi <= mul_sum[WIDTH:1];
          p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIN;
        end
        DIV: begin
          p_hi <= ge ? rem_sub : rs[WIDTH-1:0];
          p_lo <= {p_lo[WIDTH-2:0], ge};
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIN;
        end
        FIN: begin
          out_r  <= fin_lo;
          hi_r   <= fin_hi;
          flag_r <= 1'b0;
          dz_out <= dz_r;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_out  = out_r;
  assign bus.alu_hi   = hi_r;
  assign bus.flag     = flag_r;
  assign bus.div_zero = dz_out;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=32 and WIDTH=16
// against a plain-arithmetic reference model.
module tb_multicycle_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_alu_if #(.WIDTH(32), .OP_W(5)) b32 ();
  multicycle_alu_if #(.WIDTH(16), .OP_W(5)) b16 ();

  multicycle_alu #(.WIDTH(32), .OP_W(5), .SH_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.slave)
  );
  multicycle_alu #(.WIDTH(16), .OP_W(5), .SH_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(b16.slave)
  );

  typedef struct {
    logic [31:0] out;
    logic [31:0] hi;
    logic        flag;
    logic        dz;
  } res_t;

  res_t q32[$];
  res_t q16[$];
  int tests = 0;
  int fails = 0;

  function automatic void check(string nm, logic [31:0] got,
                                logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  function automatic res_t model(int w, int op,
                                 logic [31:0] a, logic [31:0] b);
    res_t r;
    logic [63:0] mask, ua, ub, o, h, p;
    longint sa, sb, q, rm;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    sh = int'(ub[5:0]) & (w - 1);
    o = 64'd0;
    h = 64'd0;
    r.flag = 1'b0;
    r.dz = 1'b0;
    case (op)
      0: o = 64'd0;
      1: o = ua + ub;
      2: o = ua - ub;
      3: o = ua & ub;
      4: o = ua | ub;
      5: o = ua ^ ub;
      6: o = ~(ua | ub);
      7: r.flag = (sa > 0);
      8: o = {63'd0, sa < sb};
      9: o = {63'd0, ua < ub};
      10: o = ua << sh;
      11: o = ua >> sh;
      12: begin p = sa >>> sh; o = p; end
      13: begin p = sa * sb; o = p; h = p >> w; end
      14: begin p = ua * ub; o = p; h = p >> w; end
      15, 16: begin
        if (ub == 64'd0) begin
          o = mask; h = ua; r.dz = 1'b1;
        end else if (op == 15) begin
          q = sa / sb; rm = sa % sb; o = q; h = rm;
        end else begin
          o = ua / ub; h = ua % ub;
        end
      end
      default: o = 64'hCCCC_CCCC_CCCC_CCCC;
    endcase
    o = o & mask;
    h = h & mask;
    r.out = o[31:0];
    r.hi = h[31:0];
    return r;
  endfunction

  always @(negedge clk) begin : mon32
    res_t e;
    if (rst_n && b32.done) begin
      if (q32.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done32: got done=1 required 0");
      end else begin
        e = q32.pop_front();
        check("out32", b32.alu_out, e.out);
        check("hi32", b32.alu_hi, e.hi);
        check("flag32", {31'd0, b32.flag}, {31'd0, e.flag});
        check("dz32", {31'd0, b32.div_zero}, {31'd0, e.dz});
        check("busy_at_done32", {31'd0, b32.busy}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon16
    res_t e;
    if (rst_n && b16.done) begin
      if (q16.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done16: got done=1 required 0");
      end else begin
        e = q16.pop_front();
        check("out16", {16'd0, b16.alu_out}, e.out);
        check("hi16", {16'd0, b16.alu_hi}, e.hi);
        check("flag16", {31'd0, b16.flag}, {31'd0, e.flag});
        check("dz16", {31'd0, b16.div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic drive(int u, logic s, int op,
                       logic [31:0] a, logic [31:0] b);
    if (u == 0) begin
      b32.start = s; b32.alu_op = op[4:0];
      b32.alu_a = a; b32.alu_b = b;
    end else begin
      b16.start = s; b16.alu_op = op[4:0];
      b16.alu_a = a[15:0]; b16.alu_b = b[15:0];
    end
  endtask

  // Drives start now; returns at the negedge of the done cycle.
  task automatic send(int u, int op, logic [31:0] a,
                      logic [31:0] b, int poke, output int lat);
    res_t e;
    logic got;
    e = model(u == 0 ? 32 : 16, op, a, b);
    drive(u, 1'b1, op, a, b);
    if (u == 0) q32.push_back(e);
    else q16.push_back(e);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) drive(u, 1'b0, op, $urandom, $urandom);
      if (poke != 0 && lat == poke) drive(u, 1'b1, 1, 1, 1);
      if (poke != 0 && lat == poke + 1) drive(u, 1'b0, 0, 0, 0);
      @(negedge clk);
      got = (u == 0) ? b32.done : b16.done;
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout: got no done required done op=%0d", op);
    end
  endtask

  task automatic run(int u, int op, logic [31:0] a,
                     logic [31:0] b, int exp_lat);
    int lat;
    send(u, op, a, b, 0, lat);
    check($sformatf("latency_op%0d", op), lat, exp_lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int cnt;
    int u;
    logic [31:0] ra, rb;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", b32.alu_out, 32'd0);
    check("rst_hi", b32.alu_hi, 32'd0);
    check("rst_flags", {28'd0, b32.flag, b32.div_zero,
                        b32.busy, b32.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(0, 1, 32'h7FFF_FFFF, 32'h1, 1);
    check("add_ovf", b32.alu_out, 32'h8000_0000);
    run(0, 6, 32'h0, 32'h0, 1);
    check("nor", b32.alu_out, 32'hFFFF_FFFF);
    @(negedge clk);
    check("single_pulse", {31'd0, b32.done}, 32'd0);
    @(posedge clk);
    #1;
    run(0, 8, 32'hFFFF_FFFF, 32'h1, 1);
    check("slt", b32.alu_out, 32'h1);
    run(0, 9, 32'hFFFF_FFFF, 32'h1, 1);
    check("sltu", b32.alu_out, 32'h0);
    run(0, 12, 32'h8000_0000, 32'h4, 1);
    check("sra", b32.alu_out, 32'hF800_0000);

    run(0, 7, 32'h5, 32'h0, 1);
    check("bgtz_pos", {31'd0, b32.flag}, 32'd1);
    run(0, 1, 32'h1, 32'h2, 1);
    check("flag_cleared", {31'd0, b32.flag}, 32'd0);
    run(0, 7, 32'h0, 32'h0, 1);
    run(0, 7, 32'h8000_0000, 32'h0, 1);

    run(0, 13, 32'hFFFF_FFFD, 32'h7, 34);
    check("mult_hi", b32.alu_hi, 32'hFFFF_FFFF);
    check("mult_lo", b32.alu_out, 32'hFFFF_FFEB);
    run(0, 14, 32'hFFFF_FFFF, 32'h2, 34);
    check("multu_hi", b32.alu_hi, 32'h1);
    check("multu_lo", b32.alu_out, 32'hFFFF_FFFE);

    run(0, 15, 32'hFFFF_FFF9, 32'h2, 34);
    check("div_q", b32.alu_out, 32'hFFFF_FFFD);
    check("div_r", b32.alu_hi, 32'hFFFF_FFFF);
    run(0, 16, 32'h7, 32'h0, 2);
    check("dz_out", b32.alu_out, 32'hFFFF_FFFF);
    check("dz_hi", b32.alu_hi, 32'h7);
    check("dz_flag", {31'd0, b32.div_zero}, 32'd1);
    run(0, 15, 32'h8000_0000, 32'hFFFF_FFFF, 34);
    check("minneg_q", b32.alu_out, 32'h8000_0000);
    check("minneg_r", b32.alu_hi, 32'h0);
    check("dz_cleared", {31'd0, b32.div_zero}, 32'd0);

    send(0, 13, 32'h3, 32'h5, 5, lat);
    check("latency_poked", lat, 34);
    check("poked_lo", b32.alu_out, 32'd15);
    run(0, 2, 32'h10, 32'h3, 1);
    check("b2b_sub", b32.alu_out, 32'hD);

    run(1, 13, 32'h7FFF, 32'h7FFF, 18);
    check("m16_hi", {16'd0, b16.alu_hi}, 32'h3FFF);
    check("m16_lo", {16'd0, b16.alu_out}, 32'h0001);
    run(1, 14, 32'hFFFF, 32'hFFFF, 18);
    check("mu16_hi", {16'd0, b16.alu_hi}, 32'hFFFE);

    for (int i = 0; i < 90; i++) begin
      u = (i % 3 == 0) ? 1 : 0;
      ra = pick();
      rb = pick();
      send(u, $urandom_range(0, 18), ra, rb, 0, lat);
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    @(posedge clk);
    #1;
    drive(0, 1'b1, 13, 32'hFFFF_FFFD, 32'h7);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, b32.busy}, 32'd0);
    check("midrst_out", b32.alu_out, 32'd0);
    check("midrst_hi", b32.alu_hi, 32'd0);
    check("midrst_flags", {29'd0, b32.flag, b32.div_zero,
                           b32.done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.done) cnt++;
    end
    check("no_done_after_rst", cnt, 0);
    @(posedge clk);
    #1;
    run(0, 1, 32'h3, 32'h4, 1);
    check("post_rst_add", b32.alu_out, 32'h7);

    repeat (3) @(posedge clk);
    check("q32_drained", q32.size(), 0);
    check("q16_drained", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
